// File: rtl/lpm_inpad_filt_pkg.sv
// Shared constants for the pad input filter: legal parameter ranges,
// the counter width helper and the per-cycle filter action encoding.
package lpm_inpad_filt_pkg;

    localparam int LPM_WIDTH_MIN  = 1;
    localparam int LPM_WIDTH_MAX  = 64;
    localparam int LPM_SYNC_MIN   = 2;
    localparam int LPM_SYNC_MAX   = 4;
    localparam int LPM_FILTER_MIN = 1;
    localparam int LPM_FILTER_MAX = 256;

    // What the filter does to one bit on an edge
    typedef enum logic [1:0] {
        FILT_HOLD  = 2'd0,
        FILT_CLEAR = 2'd1,
        FILT_COUNT = 2'd2,
        FILT_LOAD  = 2'd3
    } filt_action_e;

    // Bits needed to count 0..depth
    function automatic int lpm_cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lpm_inpad_filt_bitfilt.sv
// One pad bit: synchronizer chain, stability counter, debounced result
// and registered rise/fall pulses.
module lpm_inpad_bitfilt
    import lpm_inpad_filt_pkg::*;
#(
    parameter int sync_stages  = 2,
    parameter int filter_depth = 4
) (
    input  logic clock,
    input  logic aclr,
    input  logic clken,
    input  logic pad,
    output logic result,
    output logic rise,
    output logic fall,
    output logic pulse_next
);

    localparam int cnt_w = lpm_cnt_width(filter_depth);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(filter_depth - 1);

    logic [sync_stages-1:0] sync_q;
    logic [cnt_w-1:0]       cnt_q;
    logic                   s;
    filt_action_e           action;

    assign s          = sync_q[sync_stages-1];
    assign pulse_next = (action == FILT_LOAD);

    // Synchronizer shifts every clock, independent of the filter enable
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], pad};
        end
    end

    // Decide this cycle's filter action from the synchronized bit and the count
    always_comb begin
        action = FILT_HOLD;
        if (clken) begin
            if (s == result) begin
                action = FILT_CLEAR;
            end else if (cnt_q == cnt_last) begin
                action = FILT_LOAD;
            end else begin
                action = FILT_COUNT;
            end
        end
    end

    // Apply the action; pulses are high only for the cycle after a load
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            cnt_q  <= '0;
            result <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (action)
                FILT_CLEAR: cnt_q <= '0;
                FILT_COUNT: cnt_q <= cnt_q + cnt_w'(1);
                FILT_LOAD: begin
                    cnt_q  <= '0;
                    result <= s;
                    rise   <= s;
                    fall   <= ~s;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lpm_inpad_filt.sv
// Pad input filter: per-bit synchronize and debounce with edge pulses,
// plus a single registered "any bit changed" flag.
module lpm_inpad_filt
    import lpm_inpad_filt_pkg::*;
#(
    parameter string lpm_type         = "lpm_inpad_filt",
    parameter int    lpm_width        = 1,
    parameter int    lpm_sync_stages  = 2,
    parameter int    lpm_filter_depth = 4,
    parameter string lpm_hint         = "UNUSED"
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 clken,
    input  logic [lpm_width-1:0] pad,
    output logic [lpm_width-1:0] result,
    output logic [lpm_width-1:0] rise,
    output logic [lpm_width-1:0] fall,
    output logic                 changed
);

    if (lpm_width < LPM_WIDTH_MIN || lpm_width > LPM_WIDTH_MAX) begin : g_bad_width
        $error("lpm_inpad_filt: lpm_width %0d outside 1..64", lpm_width);
    end
    if (lpm_sync_stages < LPM_SYNC_MIN || lpm_sync_stages > LPM_SYNC_MAX) begin : g_bad_sync
        $error("lpm_inpad_filt: lpm_sync_stages %0d outside 2..4", lpm_sync_stages);
    end
    if (lpm_filter_depth < LPM_FILTER_MIN || lpm_filter_depth > LPM_FILTER_MAX) begin : g_bad_depth
        $error("lpm_inpad_filt: lpm_filter_depth %0d outside 1..256", lpm_filter_depth);
    end
    if (lpm_type != "lpm_inpad_filt" || lpm_hint == "") begin : g_bad_ident
        $error("lpm_inpad_filt: lpm_type must be lpm_inpad_filt and lpm_hint non-empty");
    end

    logic [lpm_width-1:0] pulse_next;

    for (genvar i = 0; i < lpm_width; i++) begin : g_bit
        lpm_inpad_bitfilt #(
            .sync_stages (lpm_sync_stages),
            .filter_depth(lpm_filter_depth)
        ) u_bitfilt (
            .clock     (clock),
            .aclr      (aclr),
            .clken     (clken),
            .pad       (pad[i]),
            .result    (result[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .pulse_next(pulse_next[i])
        );
    end

    // Changed flag registered on the same edge as the per-bit pulses
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            changed <= 1'b0;
        end else begin
            changed <= |pulse_next;
        end
    end

endmodule

// File: tb/tb_lpm_inpad_filt.sv
// Directed scoreboard bench for lpm_inpad_filt in three configurations:
// A (1 bit, 2 stages, depth 4), B (8 bits, 2 stages, depth 4),
// C (1 bit, 3 stages, depth 1).
module tb_lpm_inpad_filt;

    typedef struct packed {
        logic [7:0] result;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       changed;
    } obs_t;

    typedef struct {
        int    dut;
        string name;
        obs_t  exp;
    } sb_entry_t;

    logic       clock = 1'b0;
    logic       aclr;
    logic       clken;
    logic       pad_a;
    logic [7:0] pad_b;
    logic       pad_c;

    logic       result_a, rise_a, fall_a, changed_a;
    logic [7:0] result_b, rise_b, fall_b;
    logic       changed_b;
    logic       result_c, rise_c, fall_c, changed_c;

    sb_entry_t sb[$];
    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    lpm_inpad_filt #(.lpm_width(1), .lpm_sync_stages(2), .lpm_filter_depth(4)) dut_a (
        .clock(clock), .aclr(aclr), .clken(clken), .pad(pad_a),
        .result(result_a), .rise(rise_a), .fall(fall_a), .changed(changed_a)
    );

    lpm_inpad_filt #(.lpm_width(8), .lpm_sync_stages(2), .lpm_filter_depth(4)) dut_b (
        .clock(clock), .aclr(aclr), .clken(clken), .pad(pad_b),
        .result(result_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
    );

    lpm_inpad_filt #(.lpm_width(1), .lpm_sync_stages(3), .lpm_filter_depth(1)) dut_c (
        .clock(clock), .aclr(aclr), .clken(clken), .pad(pad_c),
        .result(result_c), .rise(rise_c), .fall(fall_c), .changed(changed_c)
    );

    function automatic obs_t mk(input logic [7:0] r, input logic [7:0] ri,
                                input logic [7:0] f, input logic c);
        obs_t o;
        o.result  = r;
        o.rise    = ri;
        o.fall    = f;
        o.changed = c;
        return o;
    endfunction

    function automatic logic [7:0] b8(input bit x);
        return x ? 8'h01 : 8'h00;
    endfunction

    function automatic obs_t sample(input int dut);
        case (dut)
            0:       return mk({7'b0, result_a}, {7'b0, rise_a}, {7'b0, fall_a}, changed_a);
            1:       return mk(result_b, rise_b, fall_b, changed_b);
            default: return mk({7'b0, result_c}, {7'b0, rise_c}, {7'b0, fall_c}, changed_c);
        endcase
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got result=%h rise=%h fall=%h changed=%b, want result=%h rise=%h fall=%h changed=%b",
                     name, act.result, act.rise, act.fall, act.changed,
                     exp.result, exp.rise, exp.fall, exp.changed);
        end
    endtask

    // Called at a falling edge: drive inputs, queue the response expected
    // after the next rising edge, then advance to the following falling edge
    task automatic applyStimulus(input int dut, input logic [7:0] padv, input logic en,
                                 input string name, input obs_t exp);
        sb_entry_t e;
        case (dut)
            0:       pad_a = padv[0];
            1:       pad_b = padv;
            default: pad_c = padv[0];
        endcase
        clken = en;
        e.dut  = dut;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic doReset();
        pad_a = 1'b0;
        pad_b = 8'h00;
        pad_c = 1'b0;
        clken = 1'b1;
        aclr  = 1'b1;
        @(negedge clock);
        aclr = 1'b0;
    endtask

    // Monitor: after every rising edge, pop one expectation and compare
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e.name, sample(e.dut), e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int padv [0:18];

        aclr  = 1'b1;
        clken = 1'b1;
        pad_a = 1'b0;
        pad_b = 8'h00;
        pad_c = 1'b0;
        @(negedge clock);
        checkOutput("reset_a", sample(0), mk(8'h00, 8'h00, 8'h00, 1'b0));
        checkOutput("reset_b", sample(1), mk(8'h00, 8'h00, 8'h00, 1'b0));
        checkOutput("reset_c", sample(2), mk(8'h00, 8'h00, 8'h00, 1'b0));
        aclr = 1'b0;

        $display("[TB] step 0->1 on A, held");
        for (int n = 1; n <= 8; n++)
            applyStimulus(0, 8'h01, 1'b1, $sformatf("step_a_n%0d", n),
                          mk(b8(n >= 6), b8(n == 6), 8'h00, n == 6));
        doReset();

        $display("[TB] 3-cycle glitch on A");
        for (int n = 1; n <= 10; n++)
            applyStimulus(0, b8(n <= 3), 1'b1, $sformatf("glitch_a_n%0d", n),
                          mk(8'h00, 8'h00, 8'h00, 1'b0));
        doReset();

        $display("[TB] clken hold on A");
        for (int n = 1; n <= 8; n++)
            applyStimulus(0, 8'h01, 1'b1, $sformatf("settle_a_n%0d", n),
                          mk(b8(n >= 6), b8(n == 6), 8'h00, n == 6));
        for (int n = 1; n <= 10; n++)
            applyStimulus(0, 8'h00, 1'b0, $sformatf("hold_a_n%0d", n),
                          mk(8'h01, 8'h00, 8'h00, 1'b0));
        for (int n = 1; n <= 6; n++)
            applyStimulus(0, 8'h00, 1'b1, $sformatf("resume_a_n%0d", n),
                          mk(b8(n < 4), 8'h00, b8(n == 4), n == 4));
        doReset();

        $display("[TB] 8-bit pattern on B");
        for (int n = 1; n <= 8; n++)
            applyStimulus(1, 8'hA5, 1'b1, $sformatf("wide_up_n%0d", n),
                          mk((n >= 6) ? 8'hA5 : 8'h00, (n == 6) ? 8'hA5 : 8'h00, 8'h00, n == 6));
        for (int n = 1; n <= 8; n++)
            applyStimulus(1, 8'h0F, 1'b1, $sformatf("wide_mix_n%0d", n),
                          mk((n >= 6) ? 8'h0F : 8'hA5, (n == 6) ? 8'h0A : 8'h00,
                             (n == 6) ? 8'hA0 : 8'h00, n == 6));
        #2;
        aclr = 1'b1;
        #1;
        checkOutput("aclr_async_b", sample(1), mk(8'h00, 8'h00, 8'h00, 1'b0));
        pad_b = 8'h00;
        @(negedge clock);
        aclr = 1'b0;

        $display("[TB] aclr mid-filter on A");
        for (int n = 1; n <= 4; n++)
            applyStimulus(0, 8'h01, 1'b1, $sformatf("pend_a_n%0d", n),
                          mk(8'h00, 8'h00, 8'h00, 1'b0));
        #2;
        aclr = 1'b1;
        #1;
        checkOutput("aclr_mid_a", sample(0), mk(8'h00, 8'h00, 8'h00, 1'b0));
        @(negedge clock);
        aclr = 1'b0;
        for (int n = 1; n <= 8; n++)
            applyStimulus(0, 8'h01, 1'b1, $sformatf("restart_a_n%0d", n),
                          mk(b8(n >= 6), b8(n == 6), 8'h00, n == 6));
        doReset();

        $display("[TB] depth-1 toggling on C");
        padv[0] = 0;
        for (int n = 1; n <= 18; n++)
            padv[n] = (n <= 12) ? ((((n - 1) / 2) % 2 == 0) ? 1 : 0) : 0;
        for (int n = 1; n <= 18; n++) begin
            int r;
            int p;
            r = (n >= 4) ? padv[n-3] : 0;
            p = (n >= 5) ? padv[n-4] : 0;
            applyStimulus(2, b8(padv[n] != 0), 1'b1, $sformatf("track_c_n%0d", n),
                          mk(b8(r != 0), b8(r == 1 && p == 0), b8(r == 0 && p == 1), r != p));
        end

        @(negedge clock);
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
